aidc_lite_decomp_dispatch: RTL

//  Parametrised dispatch/merge stage between the decompression engine and N decompressors.

---
 rtl/aidc_lite_decomp_dispatch.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/aidc_lite_decomp_dispatch.sv
// aidc_lite_decomp_dispatch
//   Dispatch/merge stage between the decompression engine and NUM_DECOMP decompressors.
//   The mode field of each packet's header word picks one decompressor channel. Every
//   accepted word of that packet is forwarded to the channel one cycle later. That
//   channel's buffer write port is merged onto the shared buffer, and its done is
//   collected into a single done pulse. Protocol violations set bits in a sticky
//   error code.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   valid_i/sop_i/eop_i/data_i
//                     input stream (no backpressure); mode = data_i[MODE_WIDTH-1:0] at sop
//   dec_valid_o       one-hot per-channel word valid (registered)
//   dec_sop_o/dec_eop_o/dec_data_o
//                     registered word to the decompressors
//   dec_buf_wren_i/dec_buf_waddr_i/dec_buf_wdata_i
//                     per-channel buffer write ports, channel k at slice k
//   dec_done_i        per-channel done (pulse or level)
//   buf_wren_o/buf_waddr_o/buf_wdata_o
//                     merged shared-buffer write port (registered; addr/data hold when idle)
//   done_o            1-cycle pulse when the current packet is fully decompressed
//   busy_o            high whenever a packet is in progress
//   err_code_o        sticky flags: [0] bad mode, [1] stray word, [2] sop mid-packet,
//                     [3] done timeout, [4] write from unselected channel
//   err_clr_i         clears err_code_o; a flag set in the same cycle wins

module aidc_lite_decomp_dispatch #(
    parameter int unsigned NUM_DECOMP     = 3,
    parameter int unsigned MODE_WIDTH     = 2,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BUF_ADDR_WIDTH = 4,
    parameter int unsigned BUF_DATA_WIDTH = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 valid_i,
    input  logic                                 sop_i,
    input  logic                                 eop_i,
    input  logic [DATA_WIDTH-1:0]                data_i,
    output logic [NUM_DECOMP-1:0]                dec_valid_o,
    output logic                                 dec_sop_o,
    output logic                                 dec_eop_o,
    output logic [DATA_WIDTH-1:0]                dec_data_o,
    input  logic [NUM_DECOMP-1:0]                dec_buf_wren_i,
    input  logic [NUM_DECOMP*BUF_ADDR_WIDTH-1:0] dec_buf_waddr_i,
    input  logic [NUM_DECOMP*BUF_DATA_WIDTH-1:0] dec_buf_wdata_i,
    input  logic [NUM_DECOMP-1:0]                dec_done_i,
    output logic                                 buf_wren_o,
    output logic [BUF_ADDR_WIDTH-1:0]            buf_waddr_o,
    output logic [BUF_DATA_WIDTH-1:0]            buf_wdata_o,
    output logic                                 done_o,
    output logic                                 busy_o,
    output logic [4:0]                           err_code_o,
    input  logic                                 err_clr_i
);

    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_STREAM    = 2'd1;
    localparam logic [1:0] ST_DROP      = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    logic [1:0]                state_q, state_d;
    logic [MODE_WIDTH-1:0]     sel_q, sel_d;
    logic                      done_seen_q, done_seen_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic [4:0]                err_q, err_d;
    logic [4:0]                err_set;

    logic [NUM_DECOMP-1:0]     dec_valid_q, dec_valid_d;
    logic                      dec_sop_q, dec_eop_q;
    logic [DATA_WIDTH-1:0]     dec_data_q;
    logic                      buf_wren_q, buf_wren_d;
    logic [BUF_ADDR_WIDTH-1:0] buf_waddr_q;
    logic [BUF_DATA_WIDTH-1:0] buf_wdata_q;
    logic                      done_q, done_d;

    logic [MODE_WIDTH-1:0]     mode;
    logic                      mode_ok;
    logic [NUM_DECOMP-1:0]     sel_oh, mode_oh;
    logic                      fwd, start_sop;
    logic [NUM_DECOMP-1:0]     fwd_oh;
    logic                      write_window, wren_sel, wren_other, done_sel, timeout_hit;
    logic [BUF_ADDR_WIDTH-1:0] sel_waddr;
    logic [BUF_DATA_WIDTH-1:0] sel_wdata;

    assign mode    = data_i[MODE_WIDTH-1:0];
    assign mode_ok = 32'(mode) < NUM_DECOMP;
    // Out-of-range modes shift the bit off the top, giving an all-zero mask.
    assign mode_oh = NUM_DECOMP'(1) << mode;
    assign sel_oh  = NUM_DECOMP'(1) << sel_q;

    // Only the selected channel may write, and only while its packet is live.
    assign write_window = (state_q == ST_STREAM) || (state_q == ST_WAIT_DONE);
    assign wren_sel     = |(dec_buf_wren_i & sel_oh);
    assign wren_other   = |(dec_buf_wren_i & ~sel_oh);
    assign done_sel     = |(dec_done_i & sel_oh);
    assign timeout_hit  = cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    always_comb begin
        sel_waddr = '0;
        sel_wdata = '0;
        for (int k = 0; k < int'(NUM_DECOMP); k++) begin
            if (sel_oh[k]) begin
                sel_waddr = dec_buf_waddr_i[k*BUF_ADDR_WIDTH +: BUF_ADDR_WIDTH];
                sel_wdata = dec_buf_wdata_i[k*BUF_DATA_WIDTH +: BUF_DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        done_seen_d = done_seen_q;
        fwd         = 1'b0;
        fwd_oh      = sel_oh;
        start_sop   = 1'b0;
        done_d      = 1'b0;
        err_set     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    if (sop_i) start_sop  = 1'b1;
                    else       err_set[1] = 1'b1;
                end
            end
            ST_STREAM: begin
                if (valid_i) begin
                    if (sop_i) begin
                        // Abandon the open packet; the new header starts afresh.
                        err_set[2] = 1'b1;
                        start_sop  = 1'b1;
                    end else begin
                        fwd = 1'b1;
                        if (eop_i) state_d = ST_WAIT_DONE;
                    end
                end
            end
            ST_DROP: begin
                if (valid_i) begin
                    if (sop_i) begin
                        err_set[2] = 1'b1;
                        start_sop  = 1'b1;
                    end else if (eop_i) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (valid_i) err_set[1] = 1'b1;
                if (done_seen_q || done_sel) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    err_set[3] = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_sop) begin
            if (mode_ok) begin
                sel_d       = mode;
                fwd         = 1'b1;
                fwd_oh      = mode_oh;
                // A done already arriving with the header must not be lost.
                done_seen_d = |(dec_done_i & mode_oh);
                state_d     = eop_i ? ST_WAIT_DONE : ST_STREAM;
            end else begin
                err_set[0] = 1'b1;
                state_d    = eop_i ? ST_IDLE : ST_DROP;
            end
        end else if (write_window) begin
            done_seen_d = done_seen_q | done_sel;
        end

        err_set[4] = wren_other | (~write_window & (|dec_buf_wren_i));
    end

    assign dec_valid_d = fwd ? fwd_oh : '0;
    assign buf_wren_d  = write_window & wren_sel;
    assign cnt_d       = (state_q == ST_WAIT_DONE) ? cnt_q + CNT_WIDTH'(1) : '0;
    assign err_d       = (err_clr_i ? 5'd0 : err_q) | err_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            done_seen_q <= 1'b0;
            cnt_q       <= '0;
            err_q       <= '0;
            dec_valid_q <= '0;
            dec_sop_q   <= 1'b0;
            dec_eop_q   <= 1'b0;
            dec_data_q  <= '0;
            buf_wren_q  <= 1'b0;
            buf_waddr_q <= '0;
            buf_wdata_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            done_seen_q <= done_seen_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            dec_valid_q <= dec_valid_d;
            dec_sop_q   <= fwd & sop_i;
            dec_eop_q   <= fwd & eop_i;
            if (fwd) dec_data_q <= data_i;
            buf_wren_q  <= buf_wren_d;
            if (buf_wren_d) begin
                buf_waddr_q <= sel_waddr;
                buf_wdata_q <= sel_wdata;
            end
            done_q      <= done_d;
        end
    end

    assign dec_valid_o = dec_valid_q;
    assign dec_sop_o   = dec_sop_q;
    assign dec_eop_o   = dec_eop_q;
    assign dec_data_o  = dec_data_q;
    assign buf_wren_o  = buf_wren_q;
    assign buf_waddr_o = buf_waddr_q;
    assign buf_wdata_o = buf_wdata_q;
    assign done_o      = done_q;
    assign busy_o      = state_q != ST_IDLE;
    assign err_code_o  = err_q;

endmodule
